// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: walks from the round-10 key back to the cipher key,
// one round per cycle, and holds all 11 round keys for random-access readout.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset of entry x is (255 - x) * 8.
  logic [10:0] w_idx;

  assign w_idx  = {~i_byte, 3'b000};
  assign o_byte = SBOX[w_idx +: 8];

endmodule

module inv_key_expansion (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic [3:0]   round_number,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done
);

  localparam int unsigned KEY_W    = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned NUM_KEYS = 11;
  localparam logic [3:0]  LAST_RND = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_round, w_round_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [KEY_W-1:0]  r_key_mem [NUM_KEYS];

  logic              w_we;
  logic [3:0]        w_waddr;
  logic [KEY_W-1:0]  w_wdata;
  logic [KEY_W-1:0]  w_cur;
  logic [KEY_W-1:0]  w_prev;
  logic [WORD_W-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [WORD_W-1:0] w_p0, w_p1, w_p2, w_p3;
  logic [WORD_W-1:0] w_rot, w_sub;
  logic [7:0]        w_rcon;

  always_comb begin
    w_cur = '0;
    if (r_round <= LAST_RND) begin
      w_cur = r_key_mem[r_round];
    end
  end

  assign {w_a0, w_a1, w_a2, w_a3} = w_cur;

  // Undo one forward round: the last three words fall out by XOR of neighbours.
  assign w_p3 = w_a3 ^ w_a2;
  assign w_p2 = w_a2 ^ w_a1;
  assign w_p1 = w_a1 ^ w_a0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[g*8 +: 8]),
      .o_byte (w_sub[g*8 +: 8])
    );
  end

  always_comb begin
    w_rcon = 8'h00;
    case (r_round)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_p0   = w_a0 ^ w_sub ^ {w_rcon, 24'h000000};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_we        = 1'b0;
    w_waddr     = r_round;
    w_wdata     = w_prev;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_EXPAND;
          w_round_nxt = LAST_RND;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_we        = 1'b1;
          w_waddr     = LAST_RND;
          w_wdata     = last_key;
        end
      end
      S_EXPAND: begin
        w_we        = 1'b1;
        w_waddr     = r_round - 4'd1;
        w_round_nxt = r_round - 4'd1;
        if (r_round == 4'd1) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        r_key_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_key_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    round_key = '0;
    if (round_number <= LAST_RND) begin
      round_key = r_key_mem[round_number];
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/inv_key_expansion.md
# inv_key_expansion

Reverse AES-128 key schedule. Given the final (round-10) round key, it walks the schedule backward one round per cycle, recovering round keys 9 down to 0. It stores all 11 keys for random-access readout. It sits beside the forward key_expansion block and feeds the AES-128 inverse cipher, which consumes round keys in 10→0 order.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins reverse expansion from last_key
- last_key  input  128  round-10 key [w40,w41,w42,w43], w40 in bits 127:96
- round_number  input  4  selects which stored round key drives round_key
- round_key  output  128  stored key for round_number, same word ordering as last_key
- busy  output  1  high while expansion in progress
- done  output  1  high once all 11 keys are valid; held until next accepted start or reset

## Operation
- Storage: key_mem[0..10], 128 bits each. Round counter r, 4 bits.
- States: IDLE, EXPAND, DONE.
- IDLE/DONE + start=1 at edge:
  - key_mem[10] ← last_key, r ← 10, state ← EXPAND.
  - done ← 0, busy ← 1.
- EXPAND, each edge: recover round r-1 from a = key_mem[r] = [a0,a1,a2,a3]:
  - p3 = a3^a2, p2 = a2^a1, p1 = a1^a0.
  - p0 = a0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}.
  - key_mem[r-1] ← [p0,p1,p2,p3], r ← r-1.
  - When r==1 this edge: state ← DONE, busy ← 0, done ← 1.
- Rcon[r] for r=1..10: 01,02,04,08,10,20,40,80,1b,36.
- RotWord([b0,b1,b2,b3]) = [b1,b2,b3,b0], with b0 the MSB byte.
- SubWord uses four instances of the team's existing combinational sbox module.
- Readout: round_key = key_mem[round_number], combinational.
  - round_number 11..15 → round_key = 0.
  - Readable at any time. Entries not yet rewritten hold prior contents.
- start during EXPAND is ignored; the expansion in progress continues unchanged.
- start in DONE restarts the expansion: done drops at the accepting edge.
- last_key is sampled only at the accepting edge; later changes have no effect.

## Timing
- Reset (asynchronous assert, any time, including mid-EXPAND):
  - state = IDLE, r = 0, busy = 0, done = 0.
  - All key_mem entries = 0, so round_key = 0.
  - Any expansion in progress is aborted, with no partial done.
- Latency: start high at edge N.
  - key_mem[10] is valid after N. busy = 1 after N.
  - key_mem[9] is valid after N+1, key_mem[k] after N+(10-k).
  - done = 1 and busy = 0 after edge N+10.
- busy and done are mutually exclusive. Both are 0 only in IDLE.
- round_key follows round_number combinationally, with zero-cycle read latency.
- The inverse cipher may read key_mem[k] as soon as edge N+(10-k) has passed, without waiting for done.

## Test plan
- **FIPS-197 A.1 vector:**
  - Stimulus: reset, release, last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, pulse start, wait for done.
  - Required response: done rises exactly 10 cycles after the start edge.
  - Required round keys: round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, 9 = ac7766f319fadc2128d12941575c006e, 2 = f2c295f27a96b9435935807a7359f67f, 1 = a0fafe1788542cb123a339392a6c7605, 0 = 2b7e151628aed2a6abf7158809cf4f3c.
- **Reset values:**
  - Stimulus: assert reset asynchronously between clock edges, then sweep round_number 0..15.
  - Required response: busy=0 and done=0 immediately; round_key=0 for every round_number.
- **Reset mid-operation:**
  - Stimulus: start with the A.1 key, assert reset 4 cycles later, then release.
  - Required response: busy=0 and done=0; round_key(0)=0; a fresh start then yields round 0 = 2b7e1516…4f3c.
- **Start while busy:**
  - Stimulus: start with the A.1 key; 3 cycles later pulse start with last_key=0.
  - Required response: the second start is ignored; done still at +10 cycles; round 0 = 2b7e1516…4f3c.
- **Restart from DONE:**
  - Stimulus: after the A.1 run completes, start with last_key=b4ef5bcb3e92e21123e951cf6f8f188e, the round-10 key of an all-zero cipher key.
  - Required response: done drops at the accepting edge and re-rises 10 cycles later; round 0 = 0; round 1 = 62636363626363636263636362636363.
- **Out-of-range index:**
  - Stimulus: after done, set round_number to 11 and to 15.
  - Required response: round_key=0 in both cases.
